// File: rtl/openloop_startup_seq.sv
// Open-loop start-up sequencer: align, ramp, run and brake.
// Produces the angle and amplitude that drive the SVPWM stage.
module openloop_startup_seq #(
  parameter int ALIGN_AMP   = 200,
  parameter int ALIGN_TICKS = 1024,
  parameter int RUN_AMP     = 400,
  parameter int AMP_STEP    = 1,
  parameter int RUN_INC     = 655,
  parameter int INC_STEP    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_pwm_tick,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_fault,
  output logic [15:0] o_theta,
  output logic [8:0]  o_v_amp,
  output logic        o_en,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_BRAKE = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [9:0]  A_AMP = 10'(ALIGN_AMP);
  localparam logic [9:0]  R_AMP = 10'(RUN_AMP);
  localparam logic [9:0]  A_STP = 10'(AMP_STEP);
  localparam logic [16:0] R_INC = 17'(RUN_INC);
  localparam logic [16:0] I_STP = 17'(INC_STEP);
  localparam logic [15:0] A_TCK = 16'(ALIGN_TICKS);

  state_t      state_q, state_d;
  logic [15:0] theta_q, theta_d;
  logic [8:0]  amp_q, amp_d;
  logic [15:0] inc_q, inc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        en_q, en_d;

  logic [9:0]  amp_w;
  logic [8:0]  align_amp;
  logic [8:0]  ramp_amp;
  logic [8:0]  brake_amp;
  logic [16:0] inc_up;
  logic [15:0] ramp_inc;
  logic [15:0] cnt_nx;
  logic        ramp_done;

  // Saturating steps work on distances so nothing can wrap
  always_comb begin
    amp_w = {1'b0, amp_q};
    align_amp = A_AMP[8:0];
    if (amp_w < A_AMP && (A_AMP - amp_w) > A_STP)
      align_amp = amp_q + A_STP[8:0];
    ramp_amp = R_AMP[8:0];
    if (amp_w < R_AMP && (R_AMP - amp_w) > A_STP)
      ramp_amp = amp_q + A_STP[8:0];
    else if (amp_w > R_AMP && (amp_w - R_AMP) > A_STP)
      ramp_amp = amp_q - A_STP[8:0];
    brake_amp = '0;
    if (amp_w > A_STP)
      brake_amp = amp_q - A_STP[8:0];
    inc_up = {1'b0, inc_q} + I_STP;
    ramp_inc = (inc_up >= R_INC) ? R_INC[15:0] : inc_up[15:0];
    ramp_done = (ramp_inc == R_INC[15:0]) &&
                (ramp_amp == R_AMP[8:0]);
    cnt_nx = cnt_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    theta_d = theta_q;
    amp_d   = amp_q;
    inc_d   = inc_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    if (i_fault) begin
      state_d = S_FAULT;
      amp_d   = '0;
      inc_d   = '0;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          theta_d = '0;
          amp_d   = '0;
          inc_d   = '0;
          en_d    = 1'b0;
          if (i_start && !i_stop) begin
            state_d = S_ALIGN;
            cnt_d   = '0;
            en_d    = 1'b1;
          end
        end
        S_ALIGN: begin
          if (i_stop) begin
            state_d = S_BRAKE;
          end else if (i_pwm_tick) begin
            amp_d = align_amp;
            cnt_d = cnt_nx;
            if (cnt_nx == A_TCK) state_d = S_RAMP;
          end
        end
        S_RAMP: begin
          if (i_stop) begin
            state_d = S_BRAKE;
          end else if (i_pwm_tick) begin
            inc_d   = ramp_inc;
            theta_d = theta_q + ramp_inc;
            amp_d   = ramp_amp;
            if (ramp_done) state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            state_d = S_BRAKE;
          end else if (i_pwm_tick) begin
            theta_d = theta_q + R_INC[15:0];
          end
        end
        S_BRAKE: begin
          if (i_pwm_tick) begin
            amp_d   = brake_amp;
            theta_d = theta_q + inc_q;
            if (brake_amp == '0) begin
              state_d = S_IDLE;
              theta_d = '0;
              inc_d   = '0;
              en_d    = 1'b0;
            end
          end
        end
        S_FAULT: begin
          if (!i_start) begin
            state_d = S_IDLE;
            theta_d = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          theta_d = '0;
          amp_d   = '0;
          inc_d   = '0;
          en_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      theta_q <= '0;
      amp_q   <= '0;
      inc_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      theta_q <= theta_d;
      amp_q   <= amp_d;
      inc_q   <= inc_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  assign o_theta = theta_q;
  assign o_v_amp = amp_q;
  assign o_en    = en_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_openloop_startup_seq.sv
// Directed bench for openloop_startup_seq.
// Second instance uses quarter-turn increments to exercise wrap.
module tb_openloop_startup_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        fault = 1'b0;
  logic [15:0] theta, theta2;
  logic [8:0]  amp, amp2;
  logic        en, en2;
  logic [2:0]  st, st2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  openloop_startup_seq #(
    .ALIGN_AMP(8), .ALIGN_TICKS(16), .RUN_AMP(12),
    .AMP_STEP(2), .RUN_INC(100), .INC_STEP(25)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_pwm_tick(tick),
    .i_start(start), .i_stop(stop), .i_fault(fault),
    .o_theta(theta), .o_v_amp(amp), .o_en(en), .o_state(st)
  );

  openloop_startup_seq #(
    .ALIGN_AMP(8), .ALIGN_TICKS(16), .RUN_AMP(12),
    .AMP_STEP(2), .RUN_INC(16384), .INC_STEP(16384)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .i_pwm_tick(tick),
    .i_start(start), .i_stop(stop), .i_fault(fault),
    .o_theta(theta2), .o_v_amp(amp2), .o_en(en2), .o_state(st2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    repeat (3) clk1();
  endtask

  task automatic align16();
    start = 1'b1;
    clk1();
    start = 1'b0;
    repeat (16) do_tick();
  endtask

  initial begin
    // reset and idle
    repeat (2) clk1();
    rst_n = 1'b1;
    chk("rst_state", st, 0);
    chk("rst_theta", theta, 0);
    chk("rst_amp", amp, 0);
    chk("rst_en", en, 0);
    repeat (10) do_tick();
    chk("idle_state", st, 0);
    chk("idle_theta", theta, 0);
    chk("idle_amp", amp, 0);
    chk("idle_en", en, 0);

    // start without tick
    start = 1'b1;
    clk1();
    start = 1'b0;
    chk("start_state", st, 1);
    chk("start_en", en, 1);
    chk("start_amp", amp, 0);

    // align ramp 2,4,6,8,8...
    for (int k = 1; k <= 16; k++) begin
      do_tick();
      chk("align_amp", amp, (2 * k > 8) ? 8 : 2 * k);
      chk("align_theta", theta, 0);
      chk("align_state", st, (k < 16) ? 1 : 2);
    end
    chk("align2_state", st2, 2);

    // ramp
    do_tick();
    chk("r1_theta", theta, 25);
    chk("r1_amp", amp, 10);
    chk("r1_state", st, 2);
    chk("w1_theta", theta2, 16'h4000);
    chk("w1_state", st2, 2);
    do_tick();
    chk("r2_theta", theta, 75);
    chk("r2_amp", amp, 12);
    chk("r2_state", st, 2);
    chk("w2_theta", theta2, 16'h8000);
    chk("w2_state", st2, 3);
    do_tick();
    chk("r3_theta", theta, 150);
    chk("r3_state", st, 2);
    chk("w3_theta", theta2, 16'hC000);
    do_tick();
    chk("r4_theta", theta, 250);
    chk("r4_amp", amp, 12);
    chk("r4_state", st, 3);
    chk("w4_theta", theta2, 16'h0000);

    // run
    do_tick();
    chk("run1_theta", theta, 350);
    chk("w5_theta", theta2, 16'h4000);
    do_tick();
    chk("run2_theta", theta, 450);
    chk("run2_amp", amp, 12);
    chk("w6_theta", theta2, 16'h8000);

    // brake: stop applied without tick, then released
    stop = 1'b1;
    clk1();
    stop = 1'b0;
    chk("brk_state", st, 4);
    chk("brk_en", en, 1);
    chk("brk_theta", theta, 450);
    chk("brk_amp", amp, 12);
    for (int k = 1; k <= 5; k++) begin
      do_tick();
      chk("brk_amp_k", amp, 12 - 2 * k);
      chk("brk_theta_k", theta, 450 + 100 * k);
      chk("brk_state_k", st, 4);
    end
    do_tick();
    chk("brk6_amp", amp, 0);
    chk("brk6_state", st, 0);
    chk("brk6_en", en, 0);
    chk("brk6_theta", theta, 0);

    // fault mid-ramp, tick/start/stop on the same edge
    align16();
    chk("a2_state", st, 2);
    do_tick();
    do_tick();
    chk("a2_theta", theta, 75);
    fault = 1'b1;
    start = 1'b1;
    stop  = 1'b1;
    tick  = 1'b1;
    clk1();
    tick  = 1'b0;
    stop  = 1'b0;
    chk("flt_state", st, 5);
    chk("flt_amp", amp, 0);
    chk("flt_en", en, 0);
    chk("flt_theta", theta, 75);
    fault = 1'b0;
    clk1();
    chk("flt_hold_state", st, 5);
    chk("flt_hold_theta", theta, 75);
    start = 1'b0;
    clk1();
    chk("flt_exit_state", st, 0);
    chk("flt_exit_theta", theta, 0);
    chk("flt_exit_en", en, 0);

    // reset mid-run
    align16();
    repeat (4) do_tick();
    chk("rr_state", st, 3);
    do_tick();
    chk("rr_theta", theta, 350);
    rst_n = 1'b0;
    clk1();
    chk("rr_rst_state", st, 0);
    chk("rr_rst_theta", theta, 0);
    chk("rr_rst_amp", amp, 0);
    chk("rr_rst_en", en, 0);
    rst_n = 1'b1;
    clk1();
    chk("rr_after_state", st, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
